// File: rtl/barrel_shift_pipe_pkg.sv
// ---------------------------------------------------------------------------
// barrel_pkg
//   Shared definitions for the pipelined barrel shifter.
//   - mode_t : 2-bit shift mode (LSL, LSR, ASR, ROL)
//   - DEFAULT_WIDTH : default datapath width
//   - shw_of() : shift-amount width / pipeline depth for a given data width
// ---------------------------------------------------------------------------
package barrel_pkg;

  // Shift mode encoding as seen on in_mode.
  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROL = 2'b11
  } mode_t;

  localparam int DEFAULT_WIDTH = 16;

  // Number of shift-amount bits, which is also the number of pipeline stages.
  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// ---------------------------------------------------------------------------
// barrel_shift_pipe_if
//   Groups the upstream (in_*) and downstream (out_*) handshake buses of the
//   barrel shifter.
//   Ports (signals):
//     in_data/in_amt/in_mode/in_valid : operand beat offered by upstream
//     in_ready                        : shifter can accept a beat
//     out_data/out_zero/out_valid     : result beat presented downstream
//     out_ready                       : downstream accepts the result
//   Modports:
//     master : the environment driving operands and consuming results
//     slave  : the shifter itself
// ---------------------------------------------------------------------------
interface barrel_shift_pipe_if
  import barrel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int SHW = shw_of(WIDTH);

  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  mode_t            in_mode;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_amt, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_zero, out_valid
  );

  modport slave (
    input  in_data, in_amt, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_zero, out_valid
  );

endinterface

// File: rtl/barrel_shift_pipe_stage.sv
// ---------------------------------------------------------------------------
// barrel_stage
//   One pipeline step of the barrel shifter: shifts the incoming beat by 2^K
//   when amt bit K is set, then registers valid/data/amt/mode.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     advance     : pipeline may move this cycle (low = hold on stall)
//     up_*        : beat arriving from the previous stage (or the input bus)
//     dn_*        : registered beat handed to the next stage (or output bus)
// ---------------------------------------------------------------------------
module barrel_stage
  import barrel_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int K     = 0,
  localparam int SHW   = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,

  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [SHW-1:0]   up_amt,
  input  mode_t            up_mode,

  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  output logic [SHW-1:0]   dn_amt,
  output mode_t            dn_mode
);

  localparam int DIST = 1 << K;

  // Once this stage has applied its step, bit K is spent; clearing it leaves
  // only the amount bits still owed by later stages.
  localparam logic [SHW-1:0] CONSUMED = {{(SHW-1){1'b0}}, 1'b1} << K;

  logic [WIDTH-1:0] shifted;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   amt_q,   amt_d;
  mode_t            mode_q,  mode_d;

  // Conditional shift by 2^K. ASR replicates the sign bit of the beat as it
  // currently stands; earlier stages never change the MSB under ASR, so this
  // is still the original operand's sign. ROL wraps the MSB-side bits back in.
  always_comb begin
    shifted = up_data;
    if (up_amt[K]) begin
      case (up_mode)
        LSL:     shifted = up_data << DIST;
        LSR:     shifted = up_data >> DIST;
        ASR:     shifted = $unsigned($signed(up_data) >>> DIST);
        ROL:     shifted = (up_data << DIST) | (up_data >> (WIDTH - DIST));
        default: shifted = up_data;
      endcase
    end
  end

  // Next-state: hold everything while stalled, otherwise take the upstream
  // beat. Bubbles travel as all-zero beats so that idle operand inputs never
  // leak into the pipeline state.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    if (advance) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = shifted;
        amt_d  = up_amt & ~CONSUMED;
        mode_d = up_mode;
      end else begin
        data_d = '0;
        amt_d  = '0;
        mode_d = LSL;
      end
    end
  end

  // Stage register; reset discards whatever beat was held here.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      mode_q  <= LSL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_amt   = amt_q;
  assign dn_mode  = mode_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shift_pipe
//   Pipelined barrel shifter (LSL/LSR/ASR/ROL) with valid/ready handshakes on
//   both sides. SHW = log2(WIDTH) stages, stage k shifting by 2^k, so the
//   latency is exactly SHW cycles and throughput one beat per cycle.
//   WIDTH must be a power of two and at least 4.
//   Ports:
//     clk  : clock, all state on rising edge
//     rst  : synchronous active-high reset, flushes all beats in flight
//     bus  : barrel_shift_pipe_if.slave (in_* operand side, out_* result side)
// ---------------------------------------------------------------------------
module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  barrel_shift_pipe_if.slave bus
);

  localparam int SHW = shw_of(WIDTH);

  // Index 0 is the input bus, index k+1 is the register of stage k.
  logic             stg_valid [SHW+1];
  logic [WIDTH-1:0] stg_data  [SHW+1];
  logic [SHW-1:0]   stg_amt   [SHW+1];
  mode_t            stg_mode  [SHW+1];

  logic stall;
  logic advance;

  // The whole pipeline freezes as one unit when the result cannot leave;
  // no bubble collapsing, so a single global advance suffices.
  assign stall   = bus.out_valid & ~bus.out_ready;
  assign advance = ~stall;

  assign bus.in_ready = bus.out_ready | ~bus.out_valid;

  assign stg_valid[0] = bus.in_valid;
  assign stg_data[0]  = bus.in_data;
  assign stg_amt[0]   = bus.in_amt;
  assign stg_mode[0]  = bus.in_mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .advance  (advance),
      .up_valid (stg_valid[k]),
      .up_data  (stg_data[k]),
      .up_amt   (stg_amt[k]),
      .up_mode  (stg_mode[k]),
      .dn_valid (stg_valid[k+1]),
      .dn_data  (stg_data[k+1]),
      .dn_amt   (stg_amt[k+1]),
      .dn_mode  (stg_mode[k+1])
    );
  end

  assign bus.out_valid = stg_valid[SHW];
  assign bus.out_data  = stg_data[SHW];
  assign bus.out_zero  = (stg_data[SHW] == '0);

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_shift_pipe
//   Directed + random bench for barrel_shift_pipe (WIDTH=16). Expected results
//   are queued when a beat is accepted and compared when it leaves the DUT.
// ---------------------------------------------------------------------------
module tb_barrel_shift_pipe;
  import barrel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  barrel_shift_pipe_if #(.WIDTH(16)) bus ();

  barrel_shift_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  int          ts_q  [$];
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          stall_seen = 0;
  logic        lat_check = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] held_data = 16'h0;
  logic        held_zero = 1'b0;

  // Independent bit-level reference: each result bit picks its source bit.
  function automatic logic [15:0] refShift(input logic [15:0] d, input int a,
                                           input logic [1:0] m);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      case (m)
        2'b00:   r[i] = (i >= a) ? d[i-a] : 1'b0;
        2'b01:   r[i] = (i + a < 16) ? d[i+a] : 1'b0;
        2'b10:   r[i] = (i + a < 16) ? d[i+a] : d[15];
        default: r[i] = d[(i - a + 16) % 16];
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive after the rising edge, observe at the falling edge.
  task automatic stepCycle(input logic rs, input logic v, input logic [15:0] d,
                           input logic [3:0] a, input logic [1:0] m,
                           input logic [15:0] e, input logic r,
                           output logic acc);
    logic [15:0] exp_v;
    int          ts;
    @(posedge clk);
    cycle++;
    #1;
    rst           = rs;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_mode   = mode_t'(m);
    bus.out_ready = r;
    @(negedge clk);
    acc = 1'b0;
    if (rs) begin
      exp_q.delete();
      ts_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious beat", {15'b0, bus.out_valid}, 16'h0);
        end else begin
          exp_v = exp_q.pop_front();
          ts    = ts_q.pop_front();
          checkOutput("out_data", bus.out_data, exp_v);
          checkOutput("out_zero", {15'b0, bus.out_zero}, {15'b0, exp_v == 16'h0});
          if (lat_check) checkOutput("latency", 16'(cycle - ts), 16'd4);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        stall_seen++;
        checkOutput("in_ready during stall", {15'b0, bus.in_ready}, 16'h0);
        if (prev_stall) begin
          checkOutput("stall data hold", bus.out_data, held_data);
          checkOutput("stall zero hold", {15'b0, bus.out_zero}, {15'b0, held_zero});
        end
        prev_stall = 1'b1;
        held_data  = bus.out_data;
        held_zero  = bus.out_zero;
      end else begin
        prev_stall = 1'b0;
      end
      if (v && bus.in_ready === 1'b1) begin
        acc = 1'b1;
        exp_q.push_back(e);
        ts_q.push_back(cycle);
      end
    end
  endtask

  // Offer one beat with out_ready high until accepted (bounded).
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] a,
                               input logic [1:0] m, input logic [15:0] e);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) stepCycle(1'b0, 1'b1, d, a, m, e, 1'b1, acc);
    checkOutput("accept timeout", {15'b0, acc}, 16'h1);
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 40 && exp_q.size() != 0; t++)
      stepCycle(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 16'h0, 1'b1, acc);
    checkOutput("lost beats", 16'(exp_q.size()), 16'h0);
  endtask

  initial begin
    logic        acc;
    int          k;
    int          n_acc;
    logic [15:0] d;
    logic [3:0]  a;
    logic [1:0]  m;
    logic        v;

    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.in_amt    = 4'h0;
    bus.in_mode   = LSL;
    bus.out_ready = 1'b1;

    // Reset, with a beat offered on the reset edge that must be ignored.
    stepCycle(1'b1, 1'b0, 16'h0, 4'h0, 2'b00, 16'h0, 1'b1, acc);
    stepCycle(1'b1, 1'b1, 16'hBEEF, 4'h1, 2'b00, 16'h0, 1'b1, acc);
    stepCycle(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 16'h0, 1'b1, acc);
    checkOutput("reset out_valid", {15'b0, bus.out_valid}, 16'h0);
    checkOutput("reset out_data", bus.out_data, 16'h0);
    checkOutput("reset out_zero", {15'b0, bus.out_zero}, 16'h1);
    checkOutput("reset in_ready", {15'b0, bus.in_ready}, 16'h1);
    drain();

    // LSL sweep, back-to-back, one beat per cycle, fixed latency.
    $display("[TB] LSL sweep");
    lat_check = 1'b1;
    for (int s = 0; s < 16; s++) begin
      stepCycle(1'b0, 1'b1, 16'h4001, 4'(s), 2'b00, refShift(16'h4001, s, 2'b00), 1'b1, acc);
      checkOutput("sweep accept", {15'b0, acc}, 16'h1);
    end
    drain();

    // Mode corner cases, amt=0 pass-through and zero flag.
    $display("[TB] modes");
    applyStimulus(16'h8000, 4'd15, 2'b10, 16'hFFFF);
    applyStimulus(16'h8000, 4'd15, 2'b01, 16'h0001);
    applyStimulus(16'h4001, 4'd2,  2'b11, 16'h0005);
    applyStimulus(16'h0001, 4'd15, 2'b00, 16'h8000);
    applyStimulus(16'hA5C3, 4'd0,  2'b00, 16'hA5C3);
    applyStimulus(16'hA5C3, 4'd0,  2'b01, 16'hA5C3);
    applyStimulus(16'hA5C3, 4'd0,  2'b10, 16'hA5C3);
    applyStimulus(16'hA5C3, 4'd0,  2'b11, 16'hA5C3);
    applyStimulus(16'h0001, 4'd1,  2'b01, 16'h0000);
    applyStimulus(16'h0003, 4'd1,  2'b01, 16'h0001);
    applyStimulus(16'h7F00, 4'd4,  2'b10, 16'h07F0);
    drain();

    // Backpressure: out_ready low for cycles 6..9 of an 8-beat stream.
    $display("[TB] backpressure");
    lat_check  = 1'b0;
    stall_seen = 0;
    k = 0;
    for (int c = 0; c < 60 && (k < 8 || c < 11); c++) begin
      d = 16'h0180 + 16'(k);
      stepCycle(1'b0, k < 8, d, 4'(k), 2'(k), refShift(d, k, 2'(k)),
                !(c >= 6 && c <= 9), acc);
      if (acc) k++;
    end
    checkOutput("stall observed", {15'b0, stall_seen >= 3}, 16'h1);
    drain();

    // Reset with three beats in flight.
    $display("[TB] reset mid-stream");
    applyStimulus(16'h1234, 4'd1, 2'b00, 16'h2468);
    applyStimulus(16'h1234, 4'd2, 2'b00, 16'h48D0);
    applyStimulus(16'h1234, 4'd3, 2'b00, 16'h91A0);
    stepCycle(1'b1, 1'b0, 16'h0, 4'h0, 2'b00, 16'h0, 1'b1, acc);
    stepCycle(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 16'h0, 1'b1, acc);
    checkOutput("post-reset out_valid", {15'b0, bus.out_valid}, 16'h0);
    for (int t = 0; t < 6; t++) stepCycle(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 16'h0, 1'b1, acc);
    lat_check = 1'b1;
    applyStimulus(16'h00F0, 4'd4, 2'b11, 16'h0F00);
    drain();

    // Random traffic against the reference model.
    $display("[TB] random");
    lat_check = 1'b0;
    n_acc = 0;
    for (int t = 0; t < 60000 && n_acc < 10000; t++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 16'($urandom);
      a = 4'($urandom_range(0, 15));
      m = 2'($urandom_range(0, 3));
      stepCycle(1'b0, v, d, a, m, refShift(d, int'(a), m),
                $urandom_range(0, 3) != 0, acc);
      if (acc) n_acc++;
    end
    checkOutput("random beats accepted", {15'b0, n_acc == 10000}, 16'h1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits; SHALL be a power of two, at least 4.
REQ-002 Derived constant SHW = log2(WIDTH), default 4: shift-amount width and pipeline depth; SHALL NOT be user-overridable.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  operand.
REQ-006 in_amt  input  SHW  shift distance, 0..WIDTH-1.
REQ-007 in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
REQ-008 in_valid  input  1  input beat offered.
REQ-009 in_ready  output  1  input beat accepted when in_valid and in_ready are both high.
REQ-010 out_data  output  WIDTH  shifted result.
REQ-011 out_zero  output  1  high when out_data is 0.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.

Function
REQ-014 LSL: zero-fill from the LSB end.
REQ-015 LSR: zero-fill from the MSB end.
REQ-016 ASR: fill from the MSB end with in_data[WIDTH-1].
REQ-017 ROL: bits shifted out at the MSB end re-enter at the LSB end.
REQ-018 The pipeline SHALL have SHW register stages. Stage k conditionally shifts by 2^k when amt bit k is set; k=0 is processed first.
REQ-019 Each stage SHALL carry valid, data, the remaining amt bits and mode alongside the data.
REQ-020 Latency SHALL be exactly SHW cycles from acceptance to out_valid when the pipeline is not stalled.
REQ-021 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-022 Stall condition: out_valid=1 and out_ready=0. During a stall every stage SHALL hold its contents, and in_ready SHALL be 0.
REQ-023 in_ready SHALL be combinational: in_ready = out_ready OR NOT out_valid.
REQ-024 Bubble handling: an empty stage SHALL advance as an invalid beat; no bubble collapsing is required.
REQ-025 out_data and out_zero SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 in_amt=0 SHALL pass in_data unchanged in all modes, with the same latency.
REQ-027 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-028 If in_valid=0, in_data, in_amt and in_mode are don't-care and SHALL NOT affect any state.

Reset
REQ-029 While rst=1 at a clock edge, all stage valid bits SHALL clear, and stage data, amt and mode SHALL clear to 0.
REQ-030 Output values one cycle after the reset edge: out_valid=0, out_data=0, out_zero=1, in_ready=1.
REQ-031 Beats in flight when rst asserts SHALL be discarded; no partial result SHALL appear afterwards.
REQ-032 rst SHALL take priority over in_valid on the same edge; a beat offered on that edge is not accepted.

Structure
REQ-033 Shared package barrel_pkg SHALL hold the mode constants (LSL, LSR, ASR, ROL) and the 2-bit mode type.
REQ-034 One sub-module, barrel_stage, parametrised by WIDTH and stage index K, SHALL implement one shift-by-2^K step plus its pipeline register and hold-on-stall.
REQ-035 The top level SHALL instantiate SHW copies of barrel_stage in a generate loop; no logic beyond stall/ready and out_zero.

Verification (WIDTH=16, latency 4)
REQ-036 LSL sweep: in_data=0x4001, mode LSL, amt 0..15 back-to-back, out_ready=1 -> outputs 0x4001, 0x8002, 0x0004, 0x0008, ... each 4 cycles after its input, one per cycle.
REQ-037 Modes: 0x8000 amt 15 -> ASR 0xFFFF, LSR 0x0001. 0x4001 ROL amt 2 -> 0x0005. 0x0001 LSL amt 15 -> 0x8000.
REQ-038 Backpressure: stream 8 beats with out_ready low for cycles 6-9 -> in_ready=0 and out_data frozen during the stall; all 8 results delivered in order with no loss.
REQ-039 Zero flag: 0x0001 LSR amt 1 -> out_data=0x0000, out_zero=1; 0x0003 LSR amt 1 -> 0x0001, out_zero=0.
REQ-040 Reset mid-stream: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 on the next cycle and none of the 3 beats ever appears; a new beat 0x00F0 ROL amt 4 -> 0x0F00 after 4 cycles.
REQ-041 Random: 10k beats with all modes and random in_valid/out_ready, checked against a reference model through a scoreboard -> zero mismatches and zero lost beats.
